// File: rtl/crc_byte_ctrl_pkg.sv
// Shared constants and types for the byte-level CRC stage controller.
// Holds the FSM state encoding, the default widths and timeout, and a
// helper that sizes the counters.
package crc_byte_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CRC_WIDTH  = 8;
  localparam int DEF_TIMEOUT    = 31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COLLECT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Number of bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/crc_byte_ctrl.sv
// Purpose: accepts a byte, clears the serial CRC stage, feeds the byte LSB first,
//          then deserialises the stage's serial CRC result into crc_byte_o.
// Latency: accept at edge 0, CLR cycle 1, SHIFT cycles 2..9, WAIT from cycle 10;
//          crc_done_o in the cycle after the last CRC bit is captured.
// Backpressure: in_ready_o is high only in IDLE; one byte in flight at a time.
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   in_data_i/_valid_i      byte input, ready via in_ready_o
//   crc_rst_n_o             active-low clear to the CRC stage
//   ser_data_o/ser_active_o serial feed to the CRC stage
//   crc_bit_i/crc_valid_i   serial result from the CRC stage
//   crc_byte_o              last collected CRC (bit 0 = first bit received)
//   crc_done_o/crc_err_o    one-cycle result / error pulses
module crc_byte_ctrl
  import crc_byte_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CRC_WIDTH  = DEF_CRC_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  crc_rst_n_o,
  output logic                  ser_data_o,
  output logic                  ser_active_o,
  input  logic                  crc_bit_i,
  input  logic                  crc_valid_i,
  output logic [CRC_WIDTH-1:0]  crc_byte_o,
  output logic                  crc_done_o,
  output logic                  crc_err_o
);

  localparam int CNT_W = cnt_width((DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH);
  localparam int TMO_W = cnt_width(TIMEOUT);

  localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] COLL_LAST = CNT_W'(CRC_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CRC_WIDTH-1:0]    coll_q, coll_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    crc_rst_n_q, crc_rst_n_d;
  logic                    ser_data_q, ser_data_d;
  logic                    ser_active_q, ser_active_d;
  logic [CRC_WIDTH-1:0]    crc_byte_q, crc_byte_d;
  logic                    crc_done_q, crc_done_d;
  logic                    crc_err_q, crc_err_d;

  assign in_ready_o   = (state_q == ST_IDLE);
  assign crc_rst_n_o  = crc_rst_n_q;
  assign ser_data_o   = ser_data_q;
  assign ser_active_o = ser_active_q;
  assign crc_byte_o   = crc_byte_q;
  assign crc_done_o   = crc_done_q;
  assign crc_err_o    = crc_err_q;

  // Outputs are registered, so each is computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    coll_d       = coll_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    crc_rst_n_d  = 1'b1;
    ser_data_d   = 1'b0;
    ser_active_d = 1'b0;
    crc_byte_d   = crc_byte_q;
    crc_done_d   = 1'b0;
    crc_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          shreg_d     = in_data_i;
          bit_cnt_d   = '0;
          crc_rst_n_d = 1'b0;
          state_d     = ST_CLR;
        end
      end
      ST_CLR: begin
        // First serial bit goes out together with leaving the clear.
        ser_active_d = 1'b1;
        ser_data_d   = shreg_q[0];
        shreg_d      = shreg_q >> 1;
        bit_cnt_d    = CNT_W'(1);
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == SHIFT_END) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          ser_active_d = 1'b1;
          ser_data_d   = shreg_q[0];
          shreg_d      = shreg_q >> 1;
          bit_cnt_d    = bit_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (crc_valid_i) begin
          // Shift in from the top so the first bit ends up in bit 0.
          coll_d    = {crc_bit_i, coll_q[CRC_WIDTH-1:1]};
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_COLLECT;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIMIT) begin
            crc_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_COLLECT: begin
        if (crc_valid_i) begin
          coll_d = {crc_bit_i, coll_q[CRC_WIDTH-1:1]};
          if (bit_cnt_q == COLL_LAST) begin
            // Result is published as DONE is entered so it is visible in DONE.
            crc_byte_d = coll_d;
            crc_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          crc_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      coll_q       <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      crc_rst_n_q  <= 1'b1;
      ser_data_q   <= 1'b0;
      ser_active_q <= 1'b0;
      crc_byte_q   <= '0;
      crc_done_q   <= 1'b0;
      crc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      coll_q       <= coll_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      crc_rst_n_q  <= crc_rst_n_d;
      ser_data_q   <= ser_data_d;
      ser_active_q <= ser_active_d;
      crc_byte_q   <= crc_byte_d;
      crc_done_q   <= crc_done_d;
      crc_err_q    <= crc_err_d;
    end
  end

endmodule

// File: tb/tb_crc_byte_ctrl.sv
// Directed bench for crc_byte_ctrl. The CRC stage is a behavioural stub
// driven from the tasks; it answers with the bitwise inverse of the byte it
// observed on the serial feed, so expected results are fixed constants.
module tb_crc_byte_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       crc_rst_n;
  logic       ser_data;
  logic       ser_active;
  logic       crc_bit;
  logic       crc_valid;
  logic [7:0] crc_byte;
  logic       crc_done;
  logic       crc_err;

  int total = 0;
  int bad   = 0;

  crc_byte_ctrl #(
    .DATA_WIDTH(8),
    .CRC_WIDTH (8),
    .TIMEOUT   (31)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .crc_rst_n_o (crc_rst_n),
    .ser_data_o  (ser_data),
    .ser_active_o(ser_active),
    .crc_bit_i   (crc_bit),
    .crc_valid_i (crc_valid),
    .crc_byte_o  (crc_byte),
    .crc_done_o  (crc_done),
    .crc_err_o   (crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hands a byte over in IDLE and runs to the first WAIT cycle, recording
  // the serial bits seen while the feed was active.
  task automatic drive_to_wait(input logic [7:0] b, output logic [7:0] seen);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    seen = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen[i] = ser_data & ser_active;
    end
    tick();
  endtask

  // Stub CRC stage: n valid cycles carrying v LSB first.
  task automatic stub_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      crc_valid = 1'b1;
      crc_bit   = v[i];
      tick();
    end
    crc_valid = 1'b0;
    crc_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (crc_rst_n !== 1'b1)  begin bad++; $display("FAIL reset_crc_rst_n got=%b want=1", crc_rst_n); end
    total++; if (ser_data !== 1'b0)   begin bad++; $display("FAIL reset_ser_data got=%b want=0", ser_data); end
    total++; if (crc_byte !== 8'h00)  begin bad++; $display("FAIL reset_crc_byte got=%h want=00", crc_byte); end
    total++; if (crc_done !== 1'b0)   begin bad++; $display("FAIL reset_crc_done got=%b want=0", crc_done); end
    total++; if (crc_err !== 1'b0)    begin bad++; $display("FAIL reset_crc_err got=%b want=0", crc_err); end
    for (int i = 0; i < 20; i++) begin
      total++; if (ser_active !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL idle_cycle%0d ser_active=%b in_ready=%b want 0/1", i, ser_active, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_shift_b4();
    logic [7:0] exp_bits;
    exp_bits = 8'hB4;  // LSB first: 0,0,1,0,1,1,0,1
    in_valid = 1'b1;
    in_data  = 8'hB4;
    tick();
    in_valid = 1'b0;
    total++; if (crc_rst_n !== 1'b0 || ser_active !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL clr_cycle rst_n=%b active=%b ready=%b want 0/0/0", crc_rst_n, ser_active, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (crc_rst_n !== 1'b1 || ser_active !== 1'b1 || ser_data !== exp_bits[i]) begin
        bad++; $display("FAIL shift_bit%0d rst_n=%b active=%b data=%b want 1/1/%b",
                        i, crc_rst_n, ser_active, ser_data, exp_bits[i]);
      end
    end
    tick();
    total++; if (ser_active !== 1'b0) begin bad++; $display("FAIL shift_end_active got=%b want=0", ser_active); end
  endtask

  // Continues from the first WAIT cycle left by test_shift_b4.
  task automatic test_collect_a5();
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      crc_valid = 1'b1;
      crc_bit   = v[i];
      tick();
      if (i < 7) begin
        total++; if (crc_done !== 1'b0) begin bad++; $display("FAIL early_done bit%0d got=%b want=0", i, crc_done); end
      end
    end
    crc_valid = 1'b0;
    crc_bit   = 1'b0;
    total++; if (crc_done !== 1'b1)  begin bad++; $display("FAIL a5_done got=%b want=1", crc_done); end
    total++; if (crc_byte !== 8'hA5) begin bad++; $display("FAIL a5_byte got=%h want=a5", crc_byte); end
    total++; if (crc_err !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL a5_done_cycle err=%b ready=%b want 0/0", crc_err, in_ready);
    end
    tick();
    total++; if (crc_done !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL a5_after done=%b ready=%b want 0/1", crc_done, in_ready);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] seen;
    drive_to_wait(8'h5A, seen);
    total++; if (seen !== 8'h5A) begin bad++; $display("FAIL tmo_serial got=%h want=5a", seen); end
    for (int k = 1; k <= 30; k++) begin
      tick();
      total++; if (crc_err !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL tmo_early k=%0d err=%b ready=%b want 0/0", k, crc_err, in_ready);
      end
    end
    tick();
    total++; if (crc_err !== 1'b1)   begin bad++; $display("FAIL tmo_err got=%b want=1", crc_err); end
    total++; if (crc_done !== 1'b0)  begin bad++; $display("FAIL tmo_done got=%b want=0", crc_done); end
    total++; if (crc_byte !== 8'hA5) begin bad++; $display("FAIL tmo_byte_hold got=%h want=a5", crc_byte); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL tmo_ready got=%b want=1", in_ready); end
    tick();
    total++; if (crc_err !== 1'b0)   begin bad++; $display("FAIL tmo_err_pulse got=%b want=0", crc_err); end
  endtask

  task automatic test_short_burst();
    logic [7:0] seen;
    drive_to_wait(8'h11, seen);
    stub_bits(8'hFF, 5);
    total++; if (crc_err !== 1'b0) begin bad++; $display("FAIL short_early_err got=%b want=0", crc_err); end
    tick();
    total++; if (crc_err !== 1'b1 || crc_done !== 1'b0) begin
      bad++; $display("FAIL short_err err=%b done=%b want 1/0", crc_err, crc_done);
    end
    total++; if (crc_byte !== 8'hA5) begin bad++; $display("FAIL short_byte_hold got=%h want=a5", crc_byte); end
    tick();
    total++; if (crc_err !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL short_after err=%b ready=%b want 0/1", crc_err, in_ready);
    end
    drive_to_wait(8'h3C, seen);
    stub_bits(~seen, 8);
    total++; if (crc_done !== 1'b1 || crc_byte !== 8'hC3) begin
      bad++; $display("FAIL next_3c done=%b byte=%h want 1/c3", crc_done, crc_byte);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen;
    drive_to_wait(8'h12, seen);
    in_valid = 1'b1;
    in_data  = 8'h34;
    stub_bits(~seen, 8);
    total++; if (crc_done !== 1'b1 || crc_byte !== 8'hED || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_first done=%b byte=%h ready=%b want 1/ed/0", crc_done, crc_byte, in_ready);
    end
    tick();
    total++; if (in_ready !== 1'b1 || crc_rst_n !== 1'b1) begin
      bad++; $display("FAIL b2b_idle ready=%b rst_n=%b want 1/1", in_ready, crc_rst_n);
    end
    tick();
    in_valid = 1'b0;
    total++; if (crc_rst_n !== 1'b0) begin bad++; $display("FAIL b2b_accept rst_n=%b want=0", crc_rst_n); end
    for (int i = 0; i < 8; i++) begin
      tick();
      seen[i] = ser_data & ser_active;
    end
    tick();
    stub_bits(~seen, 8);
    total++; if (crc_done !== 1'b1 || crc_byte !== 8'hCB) begin
      bad++; $display("FAIL b2b_second done=%b byte=%h want 1/cb", crc_done, crc_byte);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    logic [7:0] seen;
    logic [7:0] din [10];
    logic [7:0] dexp [10];
    din  = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h12, 8'hE7};
    dexp = '{8'hFF, 8'h00, 8'hFE, 8'h7F, 8'hAA, 8'h55, 8'hC3, 8'h3C, 8'hED, 8'h18};
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    total++; if (ser_active !== 1'b1) begin bad++; $display("FAIL pre_rst_active got=%b want=1", ser_active); end
    rst = 1'b1;
    #1;
    total++; if (ser_active !== 1'b0 || in_ready !== 1'b1 || crc_byte !== 8'h00 || crc_rst_n !== 1'b1) begin
      bad++; $display("FAIL mid_rst active=%b ready=%b byte=%h rst_n=%b want 0/1/00/1",
                      ser_active, in_ready, crc_byte, crc_rst_n);
    end
    tick();
    rst = 1'b0;
    tick();
    for (int n = 0; n < 10; n++) begin
      drive_to_wait(din[n], seen);
      stub_bits(~seen, 8);
      total++; if (crc_done !== 1'b1 || crc_byte !== dexp[n] || crc_err !== 1'b0) begin
        bad++; $display("FAIL seq%0d din=%h done=%b err=%b byte=%h want 1/0/%h",
                        n, din[n], crc_done, crc_err, crc_byte, dexp[n]);
      end
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    crc_bit   = 1'b0;
    crc_valid = 1'b0;
    test_reset();
    test_shift_b4();
    test_collect_a5();
    test_timeout();
    test_short_burst();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
